dest_pipe: RTL and testbench



---
 rtl/dest_pkg.sv | 23 ++
 rtl/dest_match.sv | 40 ++++
 rtl/dest_pipe.sv | 101 ++++++++++
 tb/tb_dest_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dest_pkg.sv
// Shared types for the destination-register pipeline.
// Stage entries carry a fixed-width dest field; modules use the low REG_AW bits.
package dest_pkg;

  localparam int DEST_W = 8;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_NONE = 2'b11
  } regdst_e;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic              wen;
  } entry_t;

  function automatic int fwd_sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/dest_match.sv
// One-source hazard detector and youngest-match priority encoder
// over the in-flight destination stages.
module dest_match
  import dest_pkg::*;
#(
  parameter int REG_AW   = 2,
  parameter int STAGES   = 3,
  parameter int ZERO_REG = 0
) (
  input  entry_t [STAGES-1:0] stg,
  input  logic   [REG_AW-1:0] src,
  output logic                hazard,
  output logic   [3:0]        sel
);

  localparam int SW = fwd_sel_w(STAGES);

  logic [STAGES-1:0] hit;
  logic [SW-1:0]     enc;

  always_comb begin
    hit = '0;
    for (int k = 0; k < STAGES; k++)
      hit[k] = stg[k].wen && (stg[k].dest == DEST_W'(src));
    if (ZERO_REG != 0 && src == '0)
      hit = '0;
  end

  // Walk oldest to youngest so the lowest stage index wins.
  always_comb begin
    enc = '0;
    for (int k = STAGES - 1; k >= 0; k--)
      if (hit[k])
        enc = SW'(k + 1);
  end

  assign hazard = |hit;
  assign sel    = 4'(enc);

endmodule

// File: rtl/dest_pipe.sv
// Destination-register select and pipeline with stall/flush,
// write-back port and per-source hazard/forwarding selects.
module dest_pipe
  import dest_pkg::*;
#(
  parameter int INSTR_W  = 8,
  parameter int REG_AW   = 2,
  parameter int RD_LSB   = 0,
  parameter int RT_LSB   = 2,
  parameter int STAGES   = 3,
  parameter int ZERO_REG = 0,
  parameter int LINK_REG = 2**REG_AW - 1
) (
  input  logic               Clk,
  input  logic               Clear_n,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic [1:0]         RegDst,
  input  logic               RegWrite,
  input  logic               Stall,
  input  logic               Flush,
  input  logic [REG_AW-1:0]  Src_A,
  input  logic [REG_AW-1:0]  Src_B,
  output logic [REG_AW-1:0]  Write_Register,
  output logic               Write_Enable,
  output logic               Hazard_A,
  output logic               Hazard_B,
  output logic [3:0]         Fwd_A_Sel,
  output logic [3:0]         Fwd_B_Sel
);

  entry_t [STAGES-1:0] stg;
  entry_t              cap;
  regdst_e             mode;
  logic [REG_AW-1:0]   sel_dest;
  logic                instr_unused;

  assign mode         = regdst_e'(RegDst);
  assign instr_unused = ^Instruction;

  always_comb begin
    sel_dest = '0;
    unique case (1'b1)
      mode == DST_RT:   sel_dest = Instruction[RT_LSB +: REG_AW];
      mode == DST_RD:   sel_dest = Instruction[RD_LSB +: REG_AW];
      mode == DST_LINK: sel_dest = REG_AW'(LINK_REG);
      mode == DST_NONE: sel_dest = '0;
    endcase
  end

  always_comb begin
    cap      = '0;
    cap.dest = DEST_W'(sel_dest);
    cap.wen  = RegWrite && (mode != DST_NONE)
               && !(ZERO_REG != 0 && sel_dest == '0);
  end

  // Stall parks stage0 and feeds a bubble so it cannot retire twice.
  always_ff @(posedge Clk) begin
    if (!Clear_n) begin
      stg <= '0;
    end else begin
      for (int k = 2; k < STAGES; k++)
        stg[k] <= stg[k-1];
      if (Flush) begin
        stg[0] <= '0;
        stg[1] <= '0;
      end else if (Stall) begin
        stg[1] <= '0;
      end else begin
        stg[0] <= cap;
        stg[1] <= stg[0];
      end
    end
  end

  assign Write_Register = stg[STAGES-1].dest[REG_AW-1:0];
  assign Write_Enable   = stg[STAGES-1].wen;

  dest_match #(
    .REG_AW   (REG_AW),
    .STAGES   (STAGES),
    .ZERO_REG (ZERO_REG)
  ) u_match_a (
    .stg    (stg),
    .src    (Src_A),
    .hazard (Hazard_A),
    .sel    (Fwd_A_Sel)
  );

  dest_match #(
    .REG_AW   (REG_AW),
    .STAGES   (STAGES),
    .ZERO_REG (ZERO_REG)
  ) u_match_b (
    .stg    (stg),
    .src    (Src_B),
    .hazard (Hazard_B),
    .sel    (Fwd_B_Sel)
  );

endmodule

// File: tb/tb_dest_pipe.sv
// Bench for dest_pipe: directed scenarios plus randomized traffic
// against a reference model, on ZERO_REG=0 and ZERO_REG=1 instances.
module tb_dest_pipe;

  localparam int S = 3;

  logic       Clk = 1'b0;
  logic       Clear_n;
  logic [7:0] Instruction;
  logic [1:0] RegDst;
  logic       RegWrite, Stall, Flush;
  logic [1:0] Src_A, Src_B;

  logic [1:0] wr0, wr1;
  logic       we0, we1, ha0, hb0, ha1, hb1;
  logic [3:0] fa0, fb0, fa1, fb1;

  int n_cmp = 0;
  int n_bad = 0;

  int md[2][S];
  bit mw[2][S];

  always #5 Clk = ~Clk;

  dest_pipe #(.STAGES(S), .ZERO_REG(0)) u0 (
    .Clk(Clk), .Clear_n(Clear_n), .Instruction(Instruction),
    .RegDst(RegDst), .RegWrite(RegWrite), .Stall(Stall), .Flush(Flush),
    .Src_A(Src_A), .Src_B(Src_B),
    .Write_Register(wr0), .Write_Enable(we0),
    .Hazard_A(ha0), .Hazard_B(hb0), .Fwd_A_Sel(fa0), .Fwd_B_Sel(fb0)
  );

  dest_pipe #(.STAGES(S), .ZERO_REG(1)) u1 (
    .Clk(Clk), .Clear_n(Clear_n), .Instruction(Instruction),
    .RegDst(RegDst), .RegWrite(RegWrite), .Stall(Stall), .Flush(Flush),
    .Src_A(Src_A), .Src_B(Src_B),
    .Write_Register(wr1), .Write_Enable(we1),
    .Hazard_A(ha1), .Hazard_B(hb1), .Fwd_A_Sel(fa1), .Fwd_B_Sel(fb1)
  );

  function automatic int pick(input logic [7:0] ins, input logic [1:0] rd);
    case (rd)
      2'b00:   return int'(ins[3:2]);
      2'b01:   return int'(ins[1:0]);
      2'b10:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_fwd(input int z, input logic [1:0] src);
    if (z == 1 && src == 2'd0) return 0;
    for (int k = 0; k < S; k++)
      if (mw[z][k] && md[z][k] == int'(src)) return k + 1;
    return 0;
  endfunction

  function automatic logic [12:0] expv(input int z);
    int fa, fb;
    fa = exp_fwd(z, Src_A);
    fb = exp_fwd(z, Src_B);
    return {2'(md[z][S-1]), mw[z][S-1], fa != 0, fb != 0, 4'(fa), 4'(fb)};
  endfunction

  task automatic model_step();
    int d;
    bit w;
    for (int z = 0; z < 2; z++) begin
      if (!Clear_n) begin
        for (int k = 0; k < S; k++) begin
          md[z][k] = 0;
          mw[z][k] = 0;
        end
      end else begin
        d = pick(Instruction, RegDst);
        w = RegWrite && RegDst != 2'b11 && !(z == 1 && d == 0);
        for (int k = S - 1; k >= 2; k--) begin
          md[z][k] = md[z][k-1];
          mw[z][k] = mw[z][k-1];
        end
        if (Flush || Stall) begin
          md[z][1] = 0; mw[z][1] = 0;
        end else begin
          md[z][1] = md[z][0]; mw[z][1] = mw[z][0];
        end
        if (Flush) begin
          md[z][0] = 0; mw[z][0] = 0;
        end else if (!Stall) begin
          md[z][0] = d; mw[z][0] = w;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; RegDst = 2'b11; Stall = 1'b0; Flush = 1'b0;
    Instruction = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    Clear_n = 1'b0;
    tick();
    Clear_n = 1'b1;
  endtask

  task automatic test_reset();
    Src_A = 2'd0; Src_B = 2'd0;
    do_reset();
    repeat (5) begin
      n_cmp++;
      if ({wr0, we0, fa0} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_idle got wr=%0d we=%0d fa=%0d want 0/0/0",
                 wr0, we0, fa0);
      end
      tick();
    end
  endtask

  task automatic test_modes();
    int exp_wr[3] = '{3, 1, 3};
    do_reset();
    Instruction = 8'b0110_1101; RegWrite = 1'b1;
    RegDst = 2'b00; tick();
    RegDst = 2'b01; tick();
    RegDst = 2'b10; tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (we0 !== 1'b1 || wr0 !== 2'(exp_wr[i])) begin
        n_bad++;
        $display("FAIL modes_wb%0d got wr=%0d we=%0d want wr=%0d we=1",
                 i, wr0, we0, exp_wr[i]);
      end
      tick();
    end
    n_cmp++;
    if (we0 !== 1'b0) begin
      n_bad++;
      $display("FAIL modes_tail got we=%0d want 0", we0);
    end
  endtask

  task automatic test_stall();
    int cnt = 0;
    int at = -1;
    logic [1:0] seen = 2'd0;
    do_reset();
    Instruction = {6'($urandom), 2'b01}; RegDst = 2'b01; RegWrite = 1'b1;
    tick();
    repeat (2) begin
      Stall = 1'b1;
      Instruction = 8'($urandom); RegDst = 2'($urandom); RegWrite = 1'b1;
      tick();
    end
    idle();
    for (int c = 3; c <= 10; c++) begin
      if (c < 5) begin
        n_cmp++;
        if (we0 !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_bubble cyc %0d got we=%0d want 0", c, we0);
        end
      end
      if (we0 === 1'b1) begin
        cnt++;
        at = c;
        seen = wr0;
      end
      tick();
    end
    n_cmp++;
    if (cnt != 1 || at != 5 || seen !== 2'd1) begin
      n_bad++;
      $display("FAIL stall_wb got count=%0d cyc=%0d wr=%0d want 1/5/1",
               cnt, at, seen);
    end
  endtask

  task automatic test_flush();
    int cnt = 0;
    int bad = 0;
    int at = -1;
    do_reset();
    Instruction = {4'($urandom), 2'b10, 2'($urandom)};
    RegDst = 2'b00; RegWrite = 1'b1;
    tick();
    Flush = 1'b1; Stall = 1'b1;
    Instruction = {4'($urandom), 2'b10, 2'($urandom)};
    tick();
    Flush = 1'b0; Stall = 1'b0;
    Instruction = {6'($urandom), 2'b01}; RegDst = 2'b01;
    tick();
    idle();
    for (int c = 3; c <= 9; c++) begin
      if (we0 === 1'b1) begin
        cnt++;
        at = c;
        if (wr0 === 2'd2) bad++;
      end
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL flush_killed got %0d write-backs of r2 want 0", bad);
    end
    n_cmp++;
    if (cnt != 1 || at != 5) begin
      n_bad++;
      $display("FAIL flush_next got count=%0d cyc=%0d want 1/5", cnt, at);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    Instruction = {6'($urandom), 2'b10}; RegDst = 2'b01; RegWrite = 1'b1;
    Src_A = 2'd2; Src_B = 2'd1;
    #1;
    n_cmp++;
    if (ha0 !== 1'b0 || fa0 !== 4'd0) begin
      n_bad++;
      $display("FAIL hazard_self got ha=%0d fa=%0d want 0/0", ha0, fa0);
    end
    tick();
    Instruction = {6'($urandom), 2'b10};
    tick();
    idle();
    #1;
    n_cmp++;
    if ({ha0, fa0, hb0, fb0} !== {1'b1, 4'd1, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL hazard_young got ha=%0d fa=%0d hb=%0d fb=%0d want 1/1/0/0",
               ha0, fa0, hb0, fb0);
    end
    tick();
    n_cmp++;
    if ({ha0, fa0} !== {1'b1, 4'd2}) begin
      n_bad++;
      $display("FAIL hazard_age got ha=%0d fa=%0d want 1/2", ha0, fa0);
    end
  endtask

  task automatic test_zero();
    do_reset();
    Instruction = {6'($urandom), 2'b00}; RegDst = 2'b01; RegWrite = 1'b1;
    Src_A = 2'd0; Src_B = 2'd3;
    tick();
    idle();
    #1;
    n_cmp++;
    if (ha1 !== 1'b0 || fa1 !== 4'd0) begin
      n_bad++;
      $display("FAIL zero_hazard got ha=%0d fa=%0d want 0/0", ha1, fa1);
    end
    n_cmp++;
    if (ha0 !== 1'b1 || fa0 !== 4'd1) begin
      n_bad++;
      $display("FAIL zero_plain_hazard got ha=%0d fa=%0d want 1/1", ha0, fa0);
    end
    tick();
    tick();
    n_cmp++;
    if (we1 !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_wb got we=%0d want 0", we1);
    end
    n_cmp++;
    if (we0 !== 1'b1 || wr0 !== 2'd0) begin
      n_bad++;
      $display("FAIL zero_plain_wb got wr=%0d we=%0d want 0/1", wr0, we0);
    end
  endtask

  task automatic test_reset_midstall();
    do_reset();
    RegDst = 2'b01; RegWrite = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      Instruction = {6'($urandom), 2'(i)};
      tick();
    end
    n_cmp++;
    if (we0 !== 1'b1 || wr0 !== 2'd1) begin
      n_bad++;
      $display("FAIL midstall_fill got wr=%0d we=%0d want 1/1", wr0, we0);
    end
    Stall = 1'b1; Clear_n = 1'b0;
    Src_A = 2'd3; Src_B = 2'd2;
    tick();
    n_cmp++;
    if ({wr0, we0, ha0, hb0, fa0, fb0} !== 13'b0) begin
      n_bad++;
      $display("FAIL midstall_clear got wr=%0d we=%0d ha=%0d hb=%0d fa=%0d fb=%0d want all 0",
               wr0, we0, ha0, hb0, fa0, fb0);
    end
    Clear_n = 1'b1;
    idle();
    repeat (6) begin
      tick();
      n_cmp++;
      if (we0 !== 1'b0) begin
        n_bad++;
        $display("FAIL midstall_stale got we=%0d want 0", we0);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] g0, g1, e0, e1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      Clear_n     = ($urandom_range(0, 39) != 0);
      Stall       = ($urandom_range(0, 5) == 0);
      Flush       = ($urandom_range(0, 7) == 0);
      Instruction = 8'($urandom);
      RegDst      = 2'($urandom);
      RegWrite    = ($urandom_range(0, 3) != 0);
      Src_A       = 2'($urandom);
      Src_B       = 2'($urandom);
      tick();
      g0 = {wr0, we0, ha0, hb0, fa0, fb0};
      g1 = {wr1, we1, ha1, hb1, fa1, fb1};
      e0 = expv(0);
      e1 = expv(1);
      n_cmp++;
      if (g0 !== e0) begin
        n_bad++;
        $display("FAIL rand_z0 cyc %0d got %h want %h", c, g0, e0);
      end
      n_cmp++;
      if (g1 !== e1) begin
        n_bad++;
        $display("FAIL rand_z1 cyc %0d got %h want %h", c, g1, e1);
      end
    end
  endtask

  initial begin
    Clear_n = 1'b0;
    Src_A = 2'd0;
    Src_B = 2'd0;
    idle();
    test_reset();
    test_modes();
    test_stall();
    test_flush();
    test_hazard();
    test_zero();
    test_reset_midstall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
